booth_share_ctrl: RTL

//  Shares one 8-bit Booth multiplier (bgn/ibus/obus/stop interface) between two requesters.

---
 rtl/booth_share_ctrl_pkg.sv | 16 +
 rtl/booth_share_ctrl_if.sv | 48 ++++
 rtl/booth_share_ctrl_rr_arb2.sv | 23 ++
 rtl/booth_share_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/booth_share_ctrl_pkg.sv
// booth_share_ctrl_pkg: shared widths and FSM state encoding for the
// Booth multiplier sharing controller.
package booth_share_ctrl_pkg;

   localparam int OPW = 8;
   localparam int PRW = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_M = 3'd1,
      LOAD_Q = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

endpackage

// File: rtl/booth_share_ctrl_if.sv
// booth_share_ctrl_if: requester handshakes, response channels and the
// multiplier bgn/ibus/obus/stop bus seen by the sharing controller.
interface booth_share_ctrl_if;
   import booth_share_ctrl_pkg::*;

   logic           req0_valid;
   logic [OPW-1:0] req0_x;
   logic [OPW-1:0] req0_y;
   logic           req0_ready;
   logic           rsp0_valid;
   logic [PRW-1:0] rsp0_prod;
   logic           rsp0_err;
   logic           rsp0_ready;

   logic           req1_valid;
   logic [OPW-1:0] req1_x;
   logic [OPW-1:0] req1_y;
   logic           req1_ready;
   logic           rsp1_valid;
   logic [PRW-1:0] rsp1_prod;
   logic           rsp1_err;
   logic           rsp1_ready;

   logic           mul_bgn;
   logic [OPW-1:0] mul_ibus;
   logic [OPW-1:0] mul_obus;
   logic           mul_stop;
   logic           busy;

   modport slave (
      input  req0_valid, req0_x, req0_y, rsp0_ready,
      input  req1_valid, req1_x, req1_y, rsp1_ready,
      input  mul_obus, mul_stop,
      output req0_ready, rsp0_valid, rsp0_prod, rsp0_err,
      output req1_ready, rsp1_valid, rsp1_prod, rsp1_err,
      output mul_bgn, mul_ibus, busy
   );

   modport master (
      output req0_valid, req0_x, req0_y, rsp0_ready,
      output req1_valid, req1_x, req1_y, rsp1_ready,
      output mul_obus, mul_stop,
      input  req0_ready, rsp0_valid, rsp0_prod, rsp0_err,
      input  req1_ready, rsp1_valid, rsp1_prod, rsp1_err,
      input  mul_bgn, mul_ibus, busy
   );

endinterface

// File: rtl/booth_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant. rr_ptr names the side that wins
// when both requesters are valid; a lone requester always wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr_ptr,
   output logic [1:0] grant,
   output logic       any
);

   // Favour the rr_ptr side on a tie, otherwise grant whoever is asking
   always_comb begin
      grant = 2'b00;
      if (valid[0] && (!valid[1] || !rr_ptr)) begin
         grant[0] = 1'b1;
      end
      if (valid[1] && (!valid[0] || rr_ptr)) begin
         grant[1] = 1'b1;
      end
   end

   assign any = |valid;

endmodule

// File: rtl/booth_share_ctrl.sv
// booth_share_ctrl: shares one 8-bit Booth multiplier between two requesters.
// Grants round-robin, feeds x then y onto ibus, rebuilds the 16-bit product
// from the last two obus bytes before stop rises, and returns it to the owner.
// A watchdog aborts with rsp_err if stop never rises.
module booth_share_ctrl
   import booth_share_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_b,
   booth_share_ctrl_if.slave bus
);

   localparam int WDW = $clog2(TIMEOUT);
   localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

   state_t         state;
   state_t         state_nxt;
   logic           rr_ptr;
   logic           owner;
   logic [OPW-1:0] x_r;
   logic [OPW-1:0] y_r;
   logic [OPW-1:0] hist_hi;
   logic [OPW-1:0] hist_lo;
   logic [PRW-1:0] prod_r;
   logic           err_r;
   logic           stop_d;
   logic [WDW-1:0] wdog;
   logic [1:0]     grant;
   logic           any_valid;
   logic           stop_edge;
   logic           wdog_done;
   logic           rsp_take;

   rr_arb2 u_arb (
      .valid  ({bus.req1_valid, bus.req0_valid}),
      .rr_ptr (rr_ptr),
      .grant  (grant),
      .any    (any_valid)
   );

   assign stop_edge = bus.mul_stop & ~stop_d;
   assign wdog_done = (wdog == WDOG_LAST);
   assign rsp_take  = owner ? bus.rsp1_ready : bus.rsp0_ready;

   // State register; reset drops any operation in flight without a response
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus Moore outputs decoded from the state; req_ready is the only combinational grant
   always_comb begin
      state_nxt      = state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp0_prod  = '0;
      bus.rsp0_err   = 1'b0;
      bus.rsp1_valid = 1'b0;
      bus.rsp1_prod  = '0;
      bus.rsp1_err   = 1'b0;
      bus.mul_bgn    = 1'b0;
      bus.mul_ibus   = '0;
      bus.busy       = 1'b1;
      unique case (state)
         IDLE: begin
            bus.busy       = 1'b0;
            bus.req0_ready = grant[0];
            bus.req1_ready = grant[1];
            if (any_valid) begin
               state_nxt = LOAD_M;
            end
         end
         LOAD_M: begin
            bus.mul_bgn  = 1'b1;
            bus.mul_ibus = x_r;
            state_nxt    = LOAD_Q;
         end
         LOAD_Q: begin
            bus.mul_ibus = y_r;
            state_nxt    = WAIT;
         end
         WAIT: begin
            if (stop_edge || wdog_done) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (owner) begin
               bus.rsp1_valid = 1'b1;
               bus.rsp1_prod  = prod_r;
               bus.rsp1_err   = err_r;
            end else begin
               bus.rsp0_valid = 1'b1;
               bus.rsp0_prod  = prod_r;
               bus.rsp0_err   = err_r;
            end
            if (rsp_take) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture on grant, obus history and watchdog while waiting, product hold and round-robin update
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_ptr  <= 1'b0;
         owner   <= 1'b0;
         x_r     <= '0;
         y_r     <= '0;
         hist_hi <= '0;
         hist_lo <= '0;
         prod_r  <= '0;
         err_r   <= 1'b0;
         stop_d  <= 1'b0;
         wdog    <= '0;
      end else begin
         stop_d <= bus.mul_stop;
         unique case (state)
            IDLE: begin
               if (any_valid) begin
                  owner <= grant[1];
                  x_r   <= grant[1] ? bus.req1_x : bus.req0_x;
                  y_r   <= grant[1] ? bus.req1_y : bus.req0_y;
               end
            end
            LOAD_Q: begin
               wdog <= '0;
            end
            WAIT: begin
               hist_hi <= hist_lo;
               hist_lo <= bus.mul_obus;
               wdog    <= wdog + WDW'(1);
               if (stop_edge) begin
                  prod_r <= {hist_hi, hist_lo};
                  err_r  <= 1'b0;
               end else if (wdog_done) begin
                  prod_r <= '0;
                  err_r  <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_take) begin
                  rr_ptr <= ~owner;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
